// File: rtl/streaming_argmax.sv
// Streaming signed max/argmax over a runtime-length vector delivered LANES elements per beat.
// Each beat is reduced by a combinational lane tree and folded into a registered running max.
module streaming_argmax #(
    parameter  int WIDTH    = 8,
    parameter  int LANES    = 4,
    parameter  int MAX_LEN  = 64,
    localparam int LenWidth = $clog2(MAX_LEN + 1),
    localparam int IdxWidth = $clog2(MAX_LEN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LenWidth-1:0]           len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IdxWidth-1:0]           out_argmax,
    output logic signed [WIDTH-1:0]       out_max,
    output logic [1:0]                    o_dbg_state
);

    // Handshake: a beat moves on a rising edge where in_valid && in_ready; the result
    // moves where out_valid && out_ready. Neither ready depends combinationally on a valid.

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int BaseW  = $clog2(MAX_LEN + LANES + 1);
    localparam int LaneW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int Levels = (LANES > 1) ? $clog2(LANES) : 1;

    logic [1:0]              r_state;
    logic [BaseW-1:0]        r_len;
    logic [BaseW-1:0]        r_base;
    logic signed [WIDTH-1:0] r_max;
    logic [IdxWidth-1:0]     r_arg;

    logic [LenWidth-1:0]     w_len_clamped;
    logic signed [WIDTH-1:0] w_tv [Levels+1][LANES];
    logic [LaneW-1:0]        w_tl [Levels+1][LANES];
    logic                    w_tm [Levels+1][LANES];
    logic signed [WIDTH-1:0] w_bmax;
    logic [LaneW-1:0]        w_blane;
    logic [IdxWidth-1:0]     w_idx;
    logic                    w_last;
    logic                    w_take;

    assign w_len_clamped = (len > LenWidth'(MAX_LEN)) ? LenWidth'(MAX_LEN) : len;

    // Level 0 holds the raw lanes; each level pairs neighbours and forwards an odd leftover.
    always_comb begin
        int cnt;
        for (int lv = 0; lv <= Levels; lv++) begin
            for (int k = 0; k < LANES; k++) begin
                w_tv[lv][k] = '0;
                w_tl[lv][k] = '0;
                w_tm[lv][k] = 1'b0;
            end
        end
        for (int k = 0; k < LANES; k++) begin
            w_tv[0][k] = in_data[k];
            w_tl[0][k] = LaneW'(k);
            w_tm[0][k] = (r_base + BaseW'(k)) < r_len;
        end
        cnt = LANES;
        for (int lv = 0; lv < Levels; lv++) begin
            for (int i = 0; i < LANES / 2; i++) begin
                if (i < cnt / 2) begin
                    if (w_tm[lv][2*i+1] && (!w_tm[lv][2*i] || (w_tv[lv][2*i+1] > w_tv[lv][2*i]))) begin
                        w_tv[lv+1][i] = w_tv[lv][2*i+1];
                        w_tl[lv+1][i] = w_tl[lv][2*i+1];
                        w_tm[lv+1][i] = 1'b1;
                    end else begin
                        w_tv[lv+1][i] = w_tv[lv][2*i];
                        w_tl[lv+1][i] = w_tl[lv][2*i];
                        w_tm[lv+1][i] = w_tm[lv][2*i];
                    end
                end
            end
            if (cnt % 2 == 1) begin
                w_tv[lv+1][cnt/2] = w_tv[lv][cnt-1];
                w_tl[lv+1][cnt/2] = w_tl[lv][cnt-1];
                w_tm[lv+1][cnt/2] = w_tm[lv][cnt-1];
            end
            cnt = (cnt + 1) / 2;
        end
    end

    assign w_bmax  = w_tv[Levels][0];
    assign w_blane = w_tl[Levels][0];
    assign w_idx   = IdxWidth'(r_base) + IdxWidth'(w_blane);
    assign w_last  = (r_base + BaseW'(LANES)) >= r_len;
    // The first beat loads unconditionally; later beats need a strictly larger value.
    assign w_take  = (r_base == '0) || (w_bmax > r_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_base  <= '0;
            r_max   <= '0;
            r_arg   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        r_len   <= BaseW'(w_len_clamped);
                        r_base  <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (w_take) begin
                            r_max <= w_bmax;
                            r_arg <= w_idx;
                        end
                        r_base <= r_base + BaseW'(LANES);
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ACCUM);
    assign out_valid   = (r_state == DONE);
    assign out_argmax  = r_arg;
    assign out_max     = r_max;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_streaming_argmax.sv
// Self-checking bench for streaming_argmax: directed cases plus randomized vectors on a
// 4-lane and a 3-lane instance, scored against an element-by-element reference scan.
module tb_streaming_argmax;

  localparam int W  = 8;
  localparam int ML = 64;
  localparam int LW = $clog2(ML + 1);
  localparam int IW = $clog2(ML);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 start4, start3;
  logic [LW-1:0]        len;
  logic                 in_valid4, in_valid3;
  logic                 in_ready4, in_ready3;
  logic [3:0][W-1:0]    in_data4;
  logic [2:0][W-1:0]    in_data3;
  logic                 out_valid4, out_valid3;
  logic                 out_ready;
  logic [IW-1:0]        arg4, arg3;
  logic signed [W-1:0]  max4, max3;
  logic [1:0]           st4, st3;

  streaming_argmax #(.WIDTH(W), .LANES(4), .MAX_LEN(ML)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .len(len),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_argmax(arg4), .out_max(max4), .o_dbg_state(st4)
  );

  streaming_argmax #(.WIDTH(W), .LANES(3), .MAX_LEN(ML)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .len(len),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_argmax(arg3), .out_max(max3), .o_dbg_state(st3)
  );

  logic [W-1:0]    elems [256];
  logic [IW+W-1:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rdy(input int w);
    return w != 0 ? int'(in_ready3) : int'(in_ready4);
  endfunction
  function automatic int ov(input int w);
    return w != 0 ? int'(out_valid3) : int'(out_valid4);
  endfunction
  function automatic int arg(input int w);
    return w != 0 ? int'(arg3) : int'(arg4);
  endfunction
  function automatic int mx(input int w);
    return w != 0 ? int'(max3) : int'(max4);
  endfunction
  function automatic int st(input int w);
    return w != 0 ? int'(st3) : int'(st4);
  endfunction

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < 256; i++) elems[i] = W'($urandom_range(0, hi - lo) + lo);
  endtask

  // reference: scan elements in order, replace only on strictly greater -> earliest max wins
  task automatic model_push(input int eff);
    int bi;
    int bv;
    bi = 0;
    bv = $signed(elems[0]);
    for (int i = 1; i < eff; i++) begin
      if ($signed(elems[i]) > bv) begin
        bv = $signed(elems[i]);
        bi = i;
      end
    end
    exp_q.push_back({IW'(bi), W'(bv)});
  endtask

  // driver tasks: all begin and end just after a falling edge
  task automatic start_run(input int w, input int l);
    len = LW'(l);
    if (w != 0) start3 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic feed(input int w, input int nbeats, input int gaps);
    int lanes;
    int t;
    lanes = (w != 0) ? 3 : 4;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int k = 0; k < lanes; k++) begin
        if (w != 0) in_data3[k] = elems[b*3+k];
        else        in_data4[k] = elems[b*4+k];
      end
      if (w != 0) in_valid3 = 1'b1; else in_valid4 = 1'b1;
      t = 0;
      while (rdy(w) == 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("ready_timeout", 0, 1);
      @(negedge clk);
      in_valid3 = 1'b0;
      in_valid4 = 1'b0;
    end
  endtask

  task automatic finish_run(input int w, input int hold);
    logic [IW+W-1:0] e;
    int earg;
    int emax;
    check("lat_out_valid", ov(w), 1);
    check("lat_in_ready", rdy(w), 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e    = exp_q.pop_front();
    earg = int'(e[IW+W-1:W]);
    emax = int'($signed(e[W-1:0]));
    check("argmax", arg(w), earg);
    check("max", mx(w), emax);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        len = LW'(5);
        if (w != 0) start3 = 1'b1; else start4 = 1'b1;
      end
      @(negedge clk);
      start3 = 1'b0;
      start4 = 1'b0;
      check("hold_valid", ov(w), 1);
      check("hold_in_ready", rdy(w), 0);
      check("hold_argmax", arg(w), earg);
      check("hold_max", mx(w), emax);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", ov(w), 0);
    check("post_idle", st(w), 0);
    check("post_in_ready", rdy(w), 0);
    check("post_keep_argmax", arg(w), earg);
    check("post_keep_max", mx(w), emax);
  endtask

  task automatic run(input int w, input int l, input int gaps, input int hold);
    int eff;
    int lanes;
    lanes = (w != 0) ? 3 : 4;
    eff = (l > ML) ? ML : l;
    model_push(eff);
    start_run(w, l);
    feed(w, (eff + lanes - 1) / lanes, gaps);
    finish_run(w, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v1 [8];
    int v2 [8];
    int v3 [3];
    rst_n = 1'b0; start4 = 1'b0; start3 = 1'b0; len = '0;
    in_valid4 = 1'b0; in_valid3 = 1'b0; in_data4 = '0; in_data3 = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", rdy(0), 0);
    check("rst_out_valid", ov(0), 0);
    check("rst_argmax", arg(0), 0);
    check("rst_max", mx(0), 0);
    check("rst_state", st(0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // cross-beat tie keeps the first occurrence
    v1 = '{3, -1, 7, 2, 7, 0, -5, 6};
    fill_rand(0, 255);
    for (int i = 0; i < 8; i++) elems[i] = W'(v1[i]);
    run(0, 8, 0, 0);

    // masked tail lanes carry larger values that must never win
    v2 = '{1, 2, 3, 4, 5, 9, 100, 127};
    for (int i = 0; i < 8; i++) elems[i] = W'(v2[i]);
    run(0, 6, 0, 0);

    // all minimum values
    for (int i = 0; i < 4; i++) elems[i] = W'(-128);
    run(0, 4, 0, 0);

    // odd lane count, in-beat tie goes to the lower lane
    v3 = '{-5, 4, 4};
    fill_rand(0, 255);
    for (int i = 0; i < 3; i++) elems[i] = W'(v3[i]);
    run(1, 3, 0, 0);

    // gapped input, stalled output with a start pulse while DONE
    fill_rand(0, 255);
    run(0, 16, 1, 5);

    // reset after 2 of 4 beats discards the partial run
    fill_rand(0, 255);
    start_run(0, 16);
    feed(0, 2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", rdy(0), 0);
    check("midrst_out_valid", ov(0), 0);
    check("midrst_argmax", arg(0), 0);
    check("midrst_max", mx(0), 0);
    check("midrst_state", st(0), 0);
    fill_rand(0, 255);
    run(0, 4, 0, 0);

    // len=0 start is ignored
    start_run(0, 0);
    check("len0_state", st(0), 0);
    check("len0_in_ready", rdy(0), 0);
    @(negedge clk);
    check("len0_state_later", st(0), 0);

    // oversize length clamps to 64 elements = 16 beats, max at the last element
    fill_rand(-128, 126);
    elems[63] = W'(127);
    run(0, 100, 0, 1);

    // randomized vectors on both instances, sometimes with many ties
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 1) != 0) fill_rand(0, 255);
      else fill_rand(-3, 3);
      run(int'($urandom_range(0, 1)), int'($urandom_range(1, 90)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
